// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared constants for the ID-stage hazard unit and its neighbours:
//   - control word width and the bit index of each control signal
//   - default branch-resolution latency and wait-counter width
//   - FSM state encoding
//   - a packed struct bundling the hazard unit's pipeline-control outputs,
//     plus a helper to build one
// Optional feature macro used by the files that import this package:
//   HAZARD_STATS_EN (adds a saturating stall-cycle counter)
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

   localparam int CONTROL_SIZE = 8;

   // Bit positions inside the ID/EX control word
   localparam int BRANCH_SRC = 0;
   localparam int ALU_SRC    = 1;
   localparam int REG_DEST   = 2;
   localparam int MEM_READ   = 3;
   localparam int MEM_WRITE  = 4;
   localparam int BRANCH     = 5;
   localparam int REG_WRITE  = 6;
   localparam int MEM_TO_REG = 7;

   localparam int REG_ADDR_W = 5;

   // Default cycles from a jump leaving ID until MEM resolves it, and the
   // width of the counter that bounds the wait (2**CNT_W must exceed it).
   localparam int HU_BRANCH_LAT = 3;
   localparam int HU_CNT_W      = 2;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT    = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   // Pipeline-control outputs of the hazard unit, grouped so the FSM can
   // assign them in one statement per branch.
   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic ctrl_nop;
      logic waiting;
   } hu_ctrl_t;

   function automatic hu_ctrl_t hu_ctrl(input logic pc_write,
                                        input logic ifid_write,
                                        input logic ifid_flush,
                                        input logic ctrl_nop,
                                        input logic waiting);
      hu_ctrl_t c;
      c.pc_write   = pc_write;
      c.ifid_write = ifid_write;
      c.ifid_flush = ifid_flush;
      c.ctrl_nop   = ctrl_nop;
      c.waiting    = waiting;
      return c;
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_if
// Bundles the hazard unit's pipeline-side signals.
//   Inputs to the hazard unit (driven by the pipeline / master side):
//     isJump, idRs, idRt, exMemRead, exRt, branchResolved, branchTaken
//   Outputs of the hazard unit (slave side drives):
//     pcWrite, ifidWrite, ifidFlush, ctrlNop, waiting, timeout,
//     dbg_state (current FSM state, for observation only)
//     stallCount (only when HAZARD_STATS_EN is defined)
// Handshake: there is no valid/ready pairing here; every input is sampled
// each cycle and every output is a level that is meaningful every cycle.
// branchTaken is only meaningful in a cycle where branchResolved is high.
// -----------------------------------------------------------------------------
interface hazard_unit_if;
   import hazard_unit_pkg::*;

   logic                  isJump;
   logic [REG_ADDR_W-1:0] idRs;
   logic [REG_ADDR_W-1:0] idRt;
   logic                  exMemRead;
   logic [REG_ADDR_W-1:0] exRt;
   logic                  branchResolved;
   logic                  branchTaken;

   logic                  pcWrite;
   logic                  ifidWrite;
   logic                  ifidFlush;
   logic                  ctrlNop;
   logic                  waiting;
   logic                  timeout;
   logic [1:0]            dbg_state;
`ifdef HAZARD_STATS_EN
   logic [15:0]           stallCount;
`endif

   modport master (
      output isJump, idRs, idRt, exMemRead, exRt, branchResolved, branchTaken,
      input  pcWrite, ifidWrite, ifidFlush, ctrlNop, waiting, timeout, dbg_state
`ifdef HAZARD_STATS_EN
      , input stallCount
`endif
   );

   modport slave (
      input  isJump, idRs, idRt, exMemRead, exRt, branchResolved, branchTaken,
      output pcWrite, ifidWrite, ifidFlush, ctrlNop, waiting, timeout, dbg_state
`ifdef HAZARD_STATS_EN
      , output stallCount
`endif
   );

endinterface

// File: rtl/hazard_unit_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector. Flags the case where the
// instruction in EX is a load whose destination register is read by the
// instruction currently in ID.
//   idRs, idRt : source registers of the ID-stage instruction
//   exMemRead  : MemRead control bit of the EX-stage instruction
//   exRt       : destination register of the EX-stage instruction
//   loadUse    : hazard present this cycle
// -----------------------------------------------------------------------------
module load_use_detect
   import hazard_unit_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] idRs,
   input  logic [REG_ADDR_W-1:0] idRt,
   input  logic                  exMemRead,
   input  logic [REG_ADDR_W-1:0] exRt,
   output logic                  loadUse
);

   always_comb begin
      // Register 0 is hard-wired to zero, so a load into it never creates a
      // real dependency.
      loadUse = exMemRead && (exRt != '0) && ((exRt == idRs) || (exRt == idRt));
   end

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// ID-stage hazard unit. Stalls fetch for one cycle on a load-use hazard,
// and holds fetch while a jump/branch travels to MEM for resolution,
// flushing IF/ID on the release cycle if the branch was taken.
//   clock : rising-edge clock
//   reset : synchronous, active-low reset
//   hif   : hazard_unit_if.slave (pipeline inputs, stall/flush outputs,
//           sticky timeout, debug state, optional stallCount)
// Parameters:
//   BRANCH_LAT : max cycles from a jump leaving ID to resolution in MEM
//   CNT_W      : wait counter width; 2**CNT_W must exceed BRANCH_LAT
// Optional feature: define HAZARD_STATS_EN to add stallCount, a saturating
// count of cycles with pcWrite low while out of reset.
// -----------------------------------------------------------------------------
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int BRANCH_LAT = HU_BRANCH_LAT,
   parameter int CNT_W      = HU_CNT_W
) (
   input  logic      clock,
   input  logic      reset,
   hazard_unit_if.slave hif
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             taken_q, taken_d;
   logic             timeout_q, timeout_d;
   logic             load_use;
   hu_ctrl_t         ctrl;

   load_use_detect u_load_use_detect (
      .idRs      (hif.idRs),
      .idRt      (hif.idRt),
      .exMemRead (hif.exMemRead),
      .exRt      (hif.exRt),
      .loadUse   (load_use)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      taken_d   = taken_q;
      timeout_d = timeout_q;
      ctrl      = hu_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      case (state_q)
         ST_IDLE: begin
            if (load_use) begin
               // One bubble; a jump in ID waits and is re-evaluated next cycle.
               ctrl = hu_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end else if (hif.isJump) begin
               // The jump itself proceeds into EX; fetch is frozen behind it.
               ctrl    = hu_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(BRANCH_LAT - 1);
            end else begin
               ctrl = hu_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            end
         end

         ST_WAIT: begin
            ctrl = hu_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (hif.branchResolved) begin
               state_d = ST_RELEASE;
               taken_d = hif.branchTaken;
            end else if (cnt_q == '0) begin
               // No resolution within the latency bound: release as not taken
               // and remember that it happened.
               state_d   = ST_RELEASE;
               taken_d   = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_RELEASE: begin
            ctrl    = hu_ctrl(1'b1, 1'b1, taken_q, 1'b1, 1'b0);
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // While held in reset the pipeline is frozen and fed bubbles.
      if (!reset) begin
         ctrl = hu_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         taken_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         taken_q   <= taken_d;
         timeout_q <= timeout_d;
      end
   end

   assign hif.pcWrite   = ctrl.pc_write;
   assign hif.ifidWrite = ctrl.ifid_write;
   assign hif.ifidFlush = ctrl.ifid_flush;
   assign hif.ctrlNop   = ctrl.ctrl_nop;
   assign hif.waiting   = ctrl.waiting;
   assign hif.timeout   = timeout_q;
   assign hif.dbg_state = state_q;

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!ctrl.pc_write && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hif.stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Directed scenarios with literal expectations, followed by random stimulus.
// A behavioural model tracks how many cycles have passed since a jump left
// ID and whether the next cycle is the release cycle, and predicts every
// output each cycle. Define HAZARD_STATS_EN to also check stallCount.
// -----------------------------------------------------------------------------
module tb_hazard_unit;
   import hazard_unit_pkg::*;

   localparam int LAT = HU_BRANCH_LAT;

   // ---------------- clock / reset ----------------
   logic clock;
   logic reset;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   hazard_unit_if hif ();

   hazard_unit dut (
      .clock (clock),
      .reset (reset),
      .hif   (hif)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_age   : 0 when no jump is in flight, else cycles since it left ID
   // m_rel   : this cycle is the one-cycle release after a jump
   // m_flush : release cycle flushes IF/ID (branch was taken)
   int          m_age   = 0;
   bit          m_rel   = 0;
   bit          m_flush = 0;
   bit          m_tmo   = 0;
   logic [15:0] m_stall = 16'd0;

   always @(negedge clock) begin
      bit lu;
      logic [4:0] e; // {pcWrite, ifidWrite, ifidFlush, ctrlNop, waiting}
      lu = hif.exMemRead && (hif.exRt != 0) &&
           ((hif.exRt == hif.idRs) || (hif.exRt == hif.idRt));

      if (!reset)            e = 5'b00010;
      else if (m_rel)        e = {2'b11, m_flush, 2'b10};
      else if (m_age > 0)    e = 5'b00011;
      else if (lu)           e = 5'b00010;
      else if (hif.isJump)   e = 5'b00000;
      else                   e = 5'b11000;

      chk("pcWrite",   {15'd0, hif.pcWrite},   {15'd0, e[4]});
      chk("ifidWrite", {15'd0, hif.ifidWrite}, {15'd0, e[3]});
      chk("ifidFlush", {15'd0, hif.ifidFlush}, {15'd0, e[2]});
      chk("ctrlNop",   {15'd0, hif.ctrlNop},   {15'd0, e[1]});
      chk("waiting",   {15'd0, hif.waiting},   {15'd0, e[0]});
      chk("timeout",   {15'd0, hif.timeout},   {15'd0, m_tmo});
`ifdef HAZARD_STATS_EN
      chk("stallCount", hif.stallCount, m_stall);
`endif

      // Advance the model to what the next clock edge will produce.
      if (!reset) begin
         m_age = 0; m_rel = 0; m_flush = 0; m_tmo = 0; m_stall = 16'd0;
      end else begin
         if (!e[4] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
         if (m_rel) begin
            m_rel = 0;
         end else if (m_age > 0) begin
            if (hif.branchResolved) begin
               m_rel = 1; m_flush = hif.branchTaken; m_age = 0;
            end else if (m_age == LAT) begin
               m_rel = 1; m_flush = 0; m_tmo = 1; m_age = 0;
            end else begin
               m_age++;
            end
         end else if (!lu && hif.isJump) begin
            m_age = 1;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic set_in(input logic rst, input logic isj, input logic [4:0] rs,
                         input logic [4:0] rt, input logic emr, input logic [4:0] ert,
                         input logic br, input logic bt);
      reset              = rst;
      hif.isJump         = isj;
      hif.idRs           = rs;
      hif.idRt           = rt;
      hif.exMemRead      = emr;
      hif.exRt           = ert;
      hif.branchResolved = br;
      hif.branchTaken    = bt;
   endtask

   // Drive one cycle's inputs just after the rising edge, then settle just
   // after the falling edge so literal checks can follow.
   task automatic cyc(input logic rst, input logic isj, input logic [4:0] rs,
                      input logic [4:0] rt, input logic emr, input logic [4:0] ert,
                      input logic br, input logic bt);
      @(posedge clock);
      #1;
      set_in(rst, isj, rs, rt, emr, ert, br, bt);
      @(negedge clock);
      #1;
   endtask

   task automatic idle_cyc();
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset held for two cycles with isJump asserted.
      set_in(0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         #1;
         chk("rst_pcWrite", {15'd0, hif.pcWrite}, 16'd0);
         chk("rst_ctrlNop", {15'd0, hif.ctrlNop}, 16'd1);
         chk("rst_waiting", {15'd0, hif.waiting}, 16'd0);
         chk("rst_timeout", {15'd0, hif.timeout}, 16'd0);
      end
      idle_cyc();
      chk("post_rst_pcWrite", {15'd0, hif.pcWrite}, 16'd1);
      chk("post_rst_ctrlNop", {15'd0, hif.ctrlNop}, 16'd0);

      // Load-use: one bubble, then free-running again.
      cyc(1, 0, 5, 0, 1, 5, 0, 0);
      chk("lu_pcWrite", {15'd0, hif.pcWrite}, 16'd0);
      chk("lu_ctrlNop", {15'd0, hif.ctrlNop}, 16'd1);
      idle_cyc();
      chk("lu_after_pcWrite", {15'd0, hif.pcWrite}, 16'd1);
      // Load into r0 is not a hazard.
      cyc(1, 0, 0, 0, 1, 0, 0, 0);
      chk("lu_r0_pcWrite", {15'd0, hif.pcWrite}, 16'd1);

      // Jump resolved taken at cycle 2.
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      chk("jt_c0_ctrlNop", {15'd0, hif.ctrlNop}, 16'd0);
      chk("jt_c0_pcWrite", {15'd0, hif.pcWrite}, 16'd0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("jt_c1_waiting", {15'd0, hif.waiting}, 16'd1);
      cyc(1, 0, 0, 0, 0, 0, 1, 1);
      chk("jt_c2_waiting", {15'd0, hif.waiting}, 16'd1);
      idle_cyc();
      chk("jt_c3_pcWrite", {15'd0, hif.pcWrite}, 16'd1);
      chk("jt_c3_ifidFlush", {15'd0, hif.ifidFlush}, 16'd1);
      chk("jt_c3_ctrlNop", {15'd0, hif.ctrlNop}, 16'd1);
      idle_cyc();
      chk("jt_c4_ctrlNop", {15'd0, hif.ctrlNop}, 16'd0);
      chk("jt_c4_ifidFlush", {15'd0, hif.ifidFlush}, 16'd0);

      // Timeout: no resolution, WAIT lasts LAT cycles.
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < LAT; i++) begin
         idle_cyc();
         chk("to_waiting", {15'd0, hif.waiting}, 16'd1);
      end
      idle_cyc();
      chk("to_rel_pcWrite", {15'd0, hif.pcWrite}, 16'd1);
      chk("to_rel_ifidFlush", {15'd0, hif.ifidFlush}, 16'd0);
      chk("to_rel_timeout", {15'd0, hif.timeout}, 16'd1);
      idle_cyc();
      chk("to_sticky", {15'd0, hif.timeout}, 16'd1);

      // Priority: load-use beats isJump, then the jump is taken up.
      cyc(1, 1, 0, 7, 1, 7, 0, 0);
      chk("pri_pcWrite", {15'd0, hif.pcWrite}, 16'd0);
      chk("pri_ctrlNop", {15'd0, hif.ctrlNop}, 16'd1);
      cyc(1, 1, 0, 7, 0, 7, 0, 0);
      chk("pri_jump_ctrlNop", {15'd0, hif.ctrlNop}, 16'd0);
      cyc(1, 0, 0, 0, 0, 0, 1, 0);
      chk("pri_wait", {15'd0, hif.waiting}, 16'd1);
      idle_cyc();
      chk("pri_rel_ifidFlush", {15'd0, hif.ifidFlush}, 16'd0);

`ifdef HAZARD_STATS_EN
      // One load-use stall + jump in ID + two WAIT cycles = 4.
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 3, 0, 1, 3, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 1, 1);
      idle_cyc();
      idle_cyc();
      chk("stats_four", hif.stallCount, 16'd4);
`endif

      // Random stimulus checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) != 0),
             ($urandom_range(0, 3) == 0),
             5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0),
             5'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)));
      end

      @(posedge clock);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Sits in the ID stage directly downstream of the control unit.
- Consumes the control unit's isJump flag, the ID/EX-registered control word (MemRead, bit 3) and the register fields, and drives the pipeline's stall and flush signals.
- Inserts NOP bubbles by forcing the ID/EX control word to zero.
- Holds fetch while a branch or jump resolves, and handles load-use stalls.

Parameters:
- CONTROL_SIZE, 8, width of the control word; shared package constant.
- BRANCH_LAT, 3, maximum cycles from jump/branch leaving ID until MEM reports resolution; timeout bound.
- CNT_W, 2, width of the wait counter; must satisfy 2^CNT_W > BRANCH_LAT.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- isJump  in  1  ID-stage instruction is a jump or branch (from the control unit).
- idRs  in  5  rs field of the instruction in ID.
- idRt  in  5  rt field of the instruction in ID.
- exMemRead  in  1  ID/EX control bit 3 (MemRead) of the instruction in EX.
- exRt  in  5  destination rt of the instruction in EX.
- branchResolved  in  1  MEM stage reports the branch decision this cycle.
- branchTaken  in  1  branch decision; valid only with branchResolved.
- pcWrite  out  1  PC may update.
- ifidWrite  out  1  IF/ID register may load.
- ifidFlush  out  1  zero the IF/ID instruction (turn it into a NOP).
- ctrlNop  out  1  select all-zero control word into ID/EX.
- waiting  out  1  high while in the WAIT state.
- timeout  out  1  sticky; set when the wait counter expires without branchResolved.

Behaviour:
- States: IDLE, WAIT, RELEASE. State and counter are registered; outputs are combinational from state plus inputs.
- Reset (reset=0 at the clock edge):
  - state=IDLE, counter=0, timeout=0.
  - While reset is low, outputs are forced to pcWrite=0, ifidWrite=0, ctrlNop=1, ifidFlush=0, waiting=0.
- loadUse = exMemRead && exRt!=0 && (exRt==idRs || exRt==idRt).
- IDLE:
  - loadUse: pcWrite=0, ifidWrite=0, ctrlNop=1; stay in IDLE. Gives exactly one bubble per load-use match.
  - else if isJump: pcWrite=0, ifidWrite=0, ctrlNop=0 (the jump itself enters EX). Next state WAIT; counter<=BRANCH_LAT-1.
  - else: pcWrite=1, ifidWrite=1, ctrlNop=0, ifidFlush=0.
  - loadUse has priority over isJump. The jump stays in ID and is re-evaluated next cycle.
- WAIT:
  - Outputs: pcWrite=0, ifidWrite=0, ctrlNop=1, waiting=1. isJump and loadUse are ignored.
  - branchResolved: next state RELEASE; latch branchTaken into takenReg.
  - else if counter==0: next state RELEASE, takenReg<=0, timeout<=1.
  - else: counter decrements.
- RELEASE (one cycle):
  - Outputs: pcWrite=1, ifidWrite=1, ctrlNop=1, ifidFlush=takenReg.
  - Next state IDLE.
  - The PC mux source is owned by the fetch stage.
- A branchResolved pulse seen in IDLE or RELEASE is ignored.
- timeout is cleared only by reset.
- Reset asserted mid-WAIT aborts the wait and returns to IDLE on that edge.
- Counter never wraps: it saturates at 0.

Optional Feature:
- HAZARD_STATS_EN defined:
  - Adds output stallCount[15:0], reset to 0.
  - Increments once per cycle in which pcWrite=0 while reset=1.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package holds:
  - CONTROL_SIZE=8.
  - Control bit index constants: BRANCH_SRC=0, ALU_SRC=1, REG_DEST=2, MEM_READ=3, MEM_WRITE=4, BRANCH=5, REG_WRITE=6, MEM_TO_REG=7.
  - State encoding: IDLE=2'd0, WAIT=2'd1, RELEASE=2'd2.
- One natural sub-module: load_use_detect. It is combinational; inputs idRs, idRt, exMemRead, exRt; output loadUse.

Test Plan:
- Reset: hold reset=0 for 2 cycles with isJump=1 → pcWrite=0, ctrlNop=1, waiting=0, timeout=0. After release, state is IDLE.
- Load-use: exMemRead=1, exRt=5, idRs=5 for one cycle → one cycle of pcWrite=0, ctrlNop=1. With exRt=0 → no stall.
- Jump resolved as taken:
  - isJump=1 at cycle 0 → cycle 0 ctrlNop=0.
  - branchResolved=1, branchTaken=1 at cycle 2 → cycles 1–2 waiting=1.
  - Cycle 3 pcWrite=1, ifidFlush=1; cycle 4 back to IDLE.
- Timeout: isJump, then no branchResolved → WAIT lasts BRANCH_LAT=3 cycles. RELEASE has ifidFlush=0; timeout=1 and stays set.
- Priority: isJump=1 with loadUse=1 → stall cycle with no WAIT entry. Next cycle isJump alone → WAIT entered.
- HAZARD_STATS_EN: after one load-use stall plus one 2-cycle jump wait, stallCount=4 (1 load-use, 1 jump-ID, 2 WAIT).
